// File: rtl/vt_cmd_if.sv
// Host command channel for the virtual-time sequencer.
// Valid/ready handshake carrying an opcode and a time/step argument.
interface vt_cmd_if #(
  parameter int W = 32
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface

// File: rtl/virtual_time_ctrl.sv
// Run-control sequencer for the emulator virtual-time base.
// Gates virtual_time advance from host commands and peripheral holds.
module virtual_time_ctrl #(
  parameter int TIME_SCALE_WIDTH = 32,
  parameter int STEP_WIDTH       = 16,
  parameter int NUM_HOLD         = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  vt_cmd_if.slave                     cmd,
  input  logic                        abort,
  input  logic [NUM_HOLD-1:0]         hold_req,
  output logic                        tick_en,
  output logic [TIME_SCALE_WIDTH-1:0] virtual_time,
  output logic [1:0]                  state,
  output logic                        done
);
  localparam int W = TIME_SCALE_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    UNTIL = 2'd3
  } st_e;

  localparam logic [1:0] OP_PAUSE = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_UNTIL = 2'd3;

  st_e                   st;
  logic [STEP_WIDTH-1:0] remaining;
  logic [W-1:0]          target;
  logic [W-1:0]          vt_inc;
  logic [W-1:0]          vt_next;
  logic [STEP_WIDTH-1:0] step_n;
  logic                  accept;

  assign state         = st;
  assign tick_en       = (st != IDLE) && (hold_req == '0);
  assign cmd.cmd_ready = ((st == IDLE) || (st == RUN)) && !abort;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign vt_inc        = virtual_time + W'(1);
  assign vt_next       = tick_en ? vt_inc : virtual_time;
  assign step_n        = cmd.cmd_arg[STEP_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      virtual_time <= '0;
      remaining    <= '0;
      target       <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick_en) virtual_time <= vt_inc;
      if (abort) begin
        st        <= IDLE;
        remaining <= '0;
      end else begin
        unique case (st)
          IDLE, RUN: begin
            if (accept) begin
              unique case (cmd.cmd_op)
                OP_PAUSE: st <= IDLE;
                OP_RUN:   st <= RUN;
                OP_STEP: begin
                  remaining <= step_n;
                  if (step_n == '0) begin
                    st   <= IDLE;
                    done <= 1'b1;
                  end else begin
                    st <= STEP;
                  end
                end
                OP_UNTIL: begin
                  target <= cmd.cmd_arg;
                  // compare against post-edge time so a RUN tick here counts
                  if (cmd.cmd_arg == vt_next) begin
                    st   <= IDLE;
                    done <= 1'b1;
                  end else begin
                    st <= UNTIL;
                  end
                end
              endcase
            end
          end
          STEP: begin
            if (tick_en) begin
              remaining <= remaining - STEP_WIDTH'(1);
              if (remaining == STEP_WIDTH'(1)) begin
                st   <= IDLE;
                done <= 1'b1;
              end
            end
          end
          UNTIL: begin
            if (tick_en && (vt_inc == target)) begin
              st   <= IDLE;
              done <= 1'b1;
            end
          end
        endcase
      end
    end
  end
endmodule
